// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
// Constants shared by the core front end.
//   ADDR_W        instruction address width, in words
//   INSTR_W       instruction word width
//   FETCH_DEPTH   default fetch queue depth (power of two, >= 2)
//   RESET_PC      first fetch address after reset
//   fetch_entry_t one queued fetch: {pc, instr}
// -----------------------------------------------------------------------------
package proc_pkg;

  localparam int ADDR_W      = 16;
  localparam int INSTR_W     = 16;
  localparam int FETCH_DEPTH = 4;

  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// -----------------------------------------------------------------------------
// instr_fifo
// Small in-order queue. Each entry is one fetched instruction together with its PC.
// The head entry is read combinationally at rd_ptr.
//   clk_i    clock
//   rst_i    synchronous active-high reset; clears pointers, count and every entry
//   flush_i  drops all entries (pointers and count go to 0); overrides push/pop
//   push_i   write wdata_i at the tail (ignored when full without a pop)
//   pop_i    drop the head entry (ignored when empty)
//   wdata_i  entry to enqueue
//   rdata_o  entry at the head
//   count_o  number of valid entries, 0..DEPTH
//   full_o   count_o == DEPTH
//   empty_o  count_o == 0
// -----------------------------------------------------------------------------
module instr_fifo
  import proc_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full queue only fits if the head leaves in the same cycle.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      // Entries are cleared so the head reads as zero, not X, after reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (!flush_i && push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/ifetch.sv
// -----------------------------------------------------------------------------
// ifetch
// Instruction fetch stage. It owns the fetch PC (fpc) and drives the asynchronous
// ROM address from it. Each fetched word is queued together with its PC and handed
// to the decoder. A redirect flushes the queue and reloads fpc.
//   i_clk       clock
//   i_rst       synchronous active-high reset (overrides redirect)
//   o_rom_addr  ROM read address = fpc register
//   i_rom_data  ROM word for o_rom_addr, same cycle
//   o_instr     instruction at the queue head
//   o_instr_pc  PC of o_instr
//   o_valid     head holds a valid instruction
//   i_ready     decoder accepts the head this cycle
//   i_redirect  taken branch/jump: flush queue, fpc <= i_target
//   i_target    redirect target PC
//
// Handshake: the head transfers on a rising edge where o_valid & i_ready.
// While o_valid is high and i_ready is low, o_instr and o_instr_pc hold steady.
// o_valid drops only after a transfer or a redirect.
// -----------------------------------------------------------------------------
module ifetch
  import proc_pkg::*;
#(
  parameter int                    ADDR_W   = proc_pkg::ADDR_W,
  parameter int                    INSTR_W  = proc_pkg::INSTR_W,
  parameter int                    DEPTH    = proc_pkg::FETCH_DEPTH,
  parameter logic [ADDR_W-1:0]     RESET_PC = proc_pkg::RESET_PC
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic [ADDR_W-1:0]  o_rom_addr,
  input  logic [INSTR_W-1:0] i_rom_data,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_instr_pc,
  output logic               o_valid,
  input  logic               i_ready,
  input  logic               i_redirect,
  input  logic [ADDR_W-1:0]  i_target
);

  localparam int EW    = ADDR_W + INSTR_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [EW-1:0]     head;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push;

  assign o_rom_addr = fpc_q;
  assign o_valid    = (count != '0);
  assign o_instr_pc = head[EW-1:INSTR_W];
  assign o_instr    = head[INSTR_W-1:0];

  // A pop in the same cycle as a redirect still counts as delivered; the decoder
  // itself discards that word.
  assign pop  = ~empty & i_ready;
  assign push = ~i_redirect & (~full | pop);

  always_comb begin
    fpc_d = fpc_q;
    if (i_redirect)  fpc_d = i_target;
    else if (push)   fpc_d = fpc_q + 1'b1;  // wraps modulo 2^ADDR_W
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) fpc_q <= RESET_PC;
    else       fpc_q <= fpc_d;
  end

  instr_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .flush_i (i_redirect),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({fpc_q, i_rom_data}),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage of the single-issue core. It owns the fetch program counter, drives the asynchronous instruction ROM address, and buffers fetched words with their PCs in a small in-order queue. It presents them to the instruction decoder over a valid/ready handshake. Branch and jump resolution from the register-file/execute stage redirects it; a redirect flushes all buffered wrong-path instructions.

## Interface
- `ADDR_W`, 16: instruction address width in words; the PC increments by 1 per instruction.
- `INSTR_W`, 16: instruction word width.
- `DEPTH`, 4: queue entries; must be a power of two, at least 2.
- `RESET_PC`, 16'h0000: first fetch address after reset.

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `o_rom_addr`  out  ADDR_W  ROM read address, driven directly from the fetch PC register.
- `i_rom_data`  in  INSTR_W  ROM word, combinationally valid for `o_rom_addr` in the same cycle.
- `o_instr`  out  INSTR_W  instruction at the queue head.
- `o_instr_pc`  out  ADDR_W  PC of the `o_instr` word.
- `o_valid`  out  1  queue head holds a valid instruction.
- `i_ready`  in  1  decoder accepts the head this cycle.
- `i_redirect`  in  1  taken branch/jump; flushes the queue and reloads the PC.
- `i_target`  in  ADDR_W  new fetch PC when `i_redirect` = 1.

## Operation
- pop = `o_valid` & `i_ready`. The head is dequeued at the clock edge.
- push = !`i_redirect` & (count < DEPTH | pop). On push, {fpc, `i_rom_data`} is written at the tail and fpc <= fpc + 1.
- fpc arithmetic is modulo 2^ADDR_W: 0xFFFF + 1 = 0x0000. No overflow flag.
- Full with pop in the same cycle: push is allowed and count is unchanged.
- Empty: push is allowed. No bypass; the pushed word becomes visible the next cycle.
- When no push occurs, fpc holds and `o_rom_addr` is stable.
- Redirect has the highest priority:
  - count <= 0 and both pointers <= 0;
  - fpc <= `i_target`;
  - no push that cycle;
  - a pop in the same cycle is considered delivered, and the decoder discards it itself.
- Redirect while empty: same action. Back-to-back redirects: the last one wins.
- Queue state: rd_ptr and wr_ptr (log2 DEPTH bits, wrapping), plus count (log2 DEPTH + 1 bits).
  - `o_valid` = (count != 0).
  - `o_instr` and `o_instr_pc` are read from the entry at rd_ptr.
  - When `o_valid` = 0, `o_instr` and `o_instr_pc` are don't-care, but they must not be X after reset.
- Reset values:
  - fpc = RESET_PC, so `o_rom_addr` = RESET_PC;
  - count, rd_ptr, wr_ptr = 0;
  - `o_valid` = 0;
  - `o_instr` = 0 and `o_instr_pc` = 0, because every entry is cleared.
- Reset mid-operation discards all queued entries; it behaves identically to power-on reset.
- Reset overrides redirect.

## Timing
- Latency from fetch to `o_valid`: 1 cycle.
- After reset release (cycle 0): fetch of RESET_PC in cycle 0, `o_valid` = 1 with `o_instr_pc` = RESET_PC in cycle 1.
- Sustained throughput: 1 instruction per cycle with `i_ready` held at 1.
- Redirect in cycle N:
  - `o_valid` = 0 in cycle N+1, while the target is fetched;
  - target instruction at the head in cycle N+2;
  - branch penalty: 2 bubbles.
- Backpressure: fetch stops once count = DEPTH. `o_rom_addr` then shows the next unfetched PC, held stable.
- `o_valid` never drops without a pop or a redirect; the head is stable while `o_valid` & !`i_ready`.

## Structure
- Shared package `proc_pkg`: ADDR_W, INSTR_W, RESET_PC constants; `fetch_entry_t` = {pc, instr}.
- One sub-module, `instr_fifo`:
  - parameterised by width and DEPTH;
  - inputs: push, pop, flush;
  - outputs: head data, count, full, empty.
- `ifetch` holds fpc, the push/pop/redirect decision and the ROM interface.

## Test plan
- Streaming: ROM[k] = 16'hA000 + k, reset at 0, `i_ready` = 1.
  - → `o_valid` rises in cycle 1 with (pc 0, A000);
  - → then (1, A001), (2, A002), … every cycle, no gaps.
- Backpressure: `i_ready` = 0 for 10 cycles after reset, then 1.
  - → count saturates at 4 and `o_rom_addr` holds 0x0004;
  - → on release, pcs 0, 1, 2, 3, 4, 5… are delivered in order with no loss or duplication.
- Full plus pop: queue full, `i_ready` = 1 for one cycle.
  - → one entry is popped and the word at pc 4 is pushed the same cycle;
  - → count stays 4.
- Redirect: queue holds 3 entries, `i_redirect` = 1 with `i_target` = 0x0040 in cycle N.
  - → `o_valid` = 0 in N+1;
  - → (0x0040, ROM[0x40]) at the head in N+2;
  - → no old-path pc appears afterwards.
- Wrap: redirect to 0xFFFF.
  - → consecutive head pcs 0xFFFF, 0x0000, 0x0001.
- Reset mid-stream: assert `i_rst` for 1 cycle with the queue full.
  - → the next cycle shows `o_valid` = 0, `o_rom_addr` = RESET_PC, `o_instr` = 0;
  - → streaming restarts from pc 0.
